// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the transmit-FIFO write side of the
// UART transmit arbiter.
//   req/valid/last  : per-requester packet request, byte strobe, end of packet
//   data            : flattened bytes, requester i at [i*DATA_ +: DATA_]
//   ready/gnt       : per-requester accept strobe and one-hot grant
//   busy/abort      : grant active, one-cycle timeout revocation pulse
//   fifo_we/din     : write port into the transmit FIFO
//   fifo_full       : transmit FIFO cannot take a write
// Modports: slave = arbiter side, master = requesters/FIFO environment.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int REQ_  = 4,
   parameter int DATA_ = 8
);
   logic [REQ_-1:0]       req;
   logic [REQ_-1:0]       valid;
   logic [REQ_*DATA_-1:0] data;
   logic [REQ_-1:0]       last;
   logic [REQ_-1:0]       ready;
   logic [REQ_-1:0]       gnt;
   logic                  busy;
   logic                  abort;
   logic                  fifo_we;
   logic [DATA_-1:0]      fifo_din;
   logic                  fifo_full;

   modport slave (
      input  req, valid, data, last, fifo_full,
      output ready, gnt, busy, abort, fifo_we, fifo_din
   );

   modport master (
      output req, valid, data, last, fifo_full,
      input  ready, gnt, busy, abort, fifo_we, fifo_din
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing the UART transmit FIFO write port between
// REQ_ requesters. A grant is held for a whole packet (until the beat flagged
// last is written, or until the owner drops req), so packets never interleave.
//
// Ports:
//   clk   : clock
//   rst_  : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (requester handshake + FIFO write port)
//
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT_ consecutive XFER cycles with no byte offered while the FIFO has
// room; revocation pulses abort. Without the macro abort is constant 0.
//
// ready and fifo_we/fifo_din are combinational from valid/fifo_full; gnt,
// busy and abort come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int REQ_     = 4,
   parameter int DATA_    = 8,
   parameter int TIMEOUT_ = 64
) (
   input  logic              clk,
   input  logic              rst_,
   uart_tx_arbiter_if.slave  bus
);
   localparam int PTR_W = (REQ_ > 1) ? $clog2(REQ_) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   if (REQ_ < 2 || TIMEOUT_ < 1) begin : g_bad_param
      $error("uart_tx_arbiter: REQ_ must be >= 2 and TIMEOUT_ >= 1");
   end

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   ptr, ptr_nxt;
   logic [PTR_W-1:0]   g, g_nxt;
   logic [REQ_-1:0]    gnt_q, gnt_nxt;
   logic               busy_q;
   logic               abort_q;
   logic [REQ_-1:0]    ready_c;
   logic               beat;
   logic [DATA_-1:0]   din_g;
   logic               tmo;

   // Index after v, wrapping from REQ_-1 back to 0.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
      if (int'(v) == REQ_ - 1) return '0;
      return v + 1'b1;
   endfunction

   // First set request scanning upward from p with wrap-around.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [REQ_-1:0] r,
                                                input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] sel;
      logic             found;
      idx   = p;
      sel   = p;
      found = 1'b0;
      for (int k = 0; k < REQ_; k++) begin
         if (!found && r[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
         idx = wrap_inc(idx);
      end
      return sel;
   endfunction

   // ---- combinational write path from the granted requester ----
   always_comb begin
      ready_c = '0;
      beat    = 1'b0;
      din_g   = bus.data[int'(g)*DATA_ +: DATA_];
      if (state == XFER) begin
         ready_c[g] = !bus.fifo_full;
         beat       = bus.valid[g] && !bus.fifo_full;
      end
   end

   assign bus.ready    = ready_c;
   assign bus.fifo_we  = beat;
   assign bus.fifo_din = din_g;
   assign bus.gnt      = gnt_q;
   assign bus.busy     = busy_q;
   assign bus.abort    = abort_q;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_ + 1);
   logic [TCNT_W-1:0] tcnt, tcnt_nxt;

   // Counts consecutive starved cycles; any beat, a full FIFO, or being out
   // of XFER resets it. Hitting the limit revokes instead of storing TIMEOUT_.
   always_comb begin
      tcnt_nxt = '0;
      tmo      = 1'b0;
      if (state == XFER && !beat && !bus.fifo_full) begin
         if (int'(tcnt) == TIMEOUT_ - 1) tmo = 1'b1;
         else                            tcnt_nxt = tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) tcnt <= '0;
      else       tcnt <= tcnt_nxt;
   end
`else
   assign tmo = 1'b0;
`endif

   // ---- next-state / arbitration ----
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      g_nxt     = g;
      gnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (|bus.req) begin
               g_nxt     = rr_pick(bus.req, ptr);
               state_nxt = XFER;
            end
         end
         XFER: begin
            // A beat offered in the same cycle as a dropped req is still written.
            if ((beat && bus.last[g]) || !bus.req[g] || tmo) begin
               state_nxt = IDLE;
               ptr_nxt   = wrap_inc(g);
            end
         end
      endcase
      if (state_nxt == XFER) gnt_nxt[g_nxt] = 1'b1;
   end

   // ---- state and registered outputs ----
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state   <= IDLE;
         ptr     <= '0;
         g       <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         g       <= g_nxt;
         gnt_q   <= gnt_nxt;
         busy_q  <= (state_nxt == XFER);
         abort_q <= tmo;
      end
   end
endmodule
